// File: rtl/commfifo_pkg.sv
// Shared types and header layout for the comm FIFO transmit arbiter.
// Frame header: tag [7:4], continuation flag [3], channel id [2:0].
package commfifo_pkg;

  localparam int unsigned ID_W         = 3;
  localparam logic [3:0]  HDR_TAG      = 4'hC;
  localparam int unsigned HDR_TAG_LSB  = 4;
  localparam int unsigned HDR_CONT_BIT = 3;
  localparam int unsigned HDR_ID_LSB   = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_CSUM = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HDR  = ST_HDR,
    DATA = ST_DATA,
    CSUM = ST_CSUM
  } state_e;

  function automatic logic [7:0] hdr_byte(input logic cont, input logic [ID_W-1:0] id);
    logic [7:0] h;
    h = '0;
    h[HDR_TAG_LSB +: 4]    = HDR_TAG;
    h[HDR_CONT_BIT]        = cont;
    h[HDR_ID_LSB +: ID_W]  = id;
    return h;
  endfunction

endpackage

// File: rtl/commfifo_rr_pick.sv
// Combinational round-robin picker: first requester searching upward from last+1 (mod NCH).
module commfifo_rr_pick
  import commfifo_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]  req,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] grant,
  output logic            any
);

  always_comb begin
    grant = '0;
    any   = 1'b0;
    // Offset i walks the ring starting just after the last grant; first hit wins.
    for (int unsigned i = 1; i <= NCH; i++) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (!any && req[k] && (k == (32'(last) + i) % NCH)) begin
          any   = 1'b1;
          grant = k[ID_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/commfifo_tx_arbiter.sv
// Round-robin, burst-framed arbiter sharing one host FIFO write port among NCH byte sources.
// Optional per-frame XOR checksum byte when COMMFIFO_TX_ARBITER_CSUM_EN is defined.
module commfifo_tx_arbiter
  import commfifo_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned MAXBURST = 16,
  parameter int unsigned BW       = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NCH-1:0]    i_req,
  input  logic [NCH*BW-1:0] i_data,
  input  logic [NCH-1:0]    i_last,
  output logic [NCH-1:0]    o_ack,
  output logic              o_wr,
  output logic [BW-1:0]     o_data,
  input  logic              i_full_n,
  output logic              o_busy,
  output logic [ID_W-1:0]   o_grant
);

  state_e          state;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] rr;
  logic [NCH-1:0]  cont;
  logic [7:0]      count;
`ifdef COMMFIFO_TX_ARBITER_CSUM_EN
  logic [BW-1:0]   csum;
`endif

  logic [ID_W-1:0] pick;
  logic            pick_any;
  logic [NCH-1:0]  gnt_oh;
  logic            req_g;
  logic            last_g;
  logic            cont_g;
  logic [BW-1:0]   data_g;
  logic            data_wr;
  logic            frame_end;

  commfifo_rr_pick #(.NCH(NCH)) u_pick (
    .req   (i_req),
    .last  (rr),
    .grant (pick),
    .any   (pick_any)
  );

  always_comb begin
    data_g = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      gnt_oh[k] = (gnt == k[ID_W-1:0]);
      if (gnt_oh[k]) data_g = i_data[k*BW +: BW];
    end
  end

  assign req_g     = |(i_req & gnt_oh);
  assign last_g    = |(i_last & gnt_oh);
  assign cont_g    = |(cont & gnt_oh);
  assign data_wr   = (state == DATA) && req_g && i_full_n;
  assign frame_end = last_g || (count == 8'(MAXBURST - 1));
  assign o_busy    = (state != IDLE);
  assign o_grant   = gnt;
  assign o_ack     = data_wr ? gnt_oh : '0;

  always_comb begin
    o_wr   = 1'b0;
    o_data = '0;
    case (state)
      HDR: if (i_full_n) begin
        o_wr   = 1'b1;
        o_data = hdr_byte(cont_g, gnt);
      end
      DATA: if (data_wr) begin
        o_wr   = 1'b1;
        o_data = data_g;
      end
`ifdef COMMFIFO_TX_ARBITER_CSUM_EN
      CSUM: if (i_full_n) begin
        o_wr   = 1'b1;
        o_data = csum;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      gnt   <= '0;
      rr    <= ID_W'(NCH - 1);
      cont  <= '0;
      count <= '0;
`ifdef COMMFIFO_TX_ARBITER_CSUM_EN
      csum  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          gnt   <= pick;
          count <= '0;
`ifdef COMMFIFO_TX_ARBITER_CSUM_EN
          csum  <= '0;
`endif
          state <= HDR;
        end
        HDR: if (i_full_n) state <= DATA;
        DATA: if (data_wr) begin
          count <= count + 8'd1;
`ifdef COMMFIFO_TX_ARBITER_CSUM_EN
          csum  <= csum ^ data_g;
`endif
          if (frame_end) begin
            // A frame cut by the burst limit (no last) marks the channel as continuing.
            cont  <= (cont & ~gnt_oh) | (last_g ? '0 : gnt_oh);
            rr    <= gnt;
`ifdef COMMFIFO_TX_ARBITER_CSUM_EN
            state <= CSUM;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef COMMFIFO_TX_ARBITER_CSUM_EN
        CSUM: if (i_full_n) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/commfifo_tx_arbiter.md
Name: commfifo_tx_arbiter

Overview:
Shares the single DUT-to-host byte FIFO write port among NCH on-chip byte sources, e.g. the APB CPU path, a trace unit and a DMA stream. Sources are served round-robin in bounded bursts. Each burst is framed with a header byte carrying the channel ID, so the host-side cosim routine can demultiplex the stream. The block sits between the sources and the ufifo write side (i_wr/i_data/o_status[0] "not full").

Parameters:
NCH, 4, number of requesting channels (2..8)
MAXBURST, 16, maximum data bytes per frame before the channel must re-arbitrate (1..255)
BW, 8, data byte width; fixed at 8, other values are unsupported

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_req  in  NCH  per-channel valid: byte on i_data slice is ready
i_data  in  NCH*8  per-channel byte; channel k on bits [8k+7:8k]
i_last  in  NCH  per-channel end-of-message flag, qualified by i_req
o_ack  out  NCH  one-cycle pop to the granted channel, asserted when its byte is written
o_wr  out  1  FIFO write strobe
o_data  out  8  FIFO write byte
i_full_n  in  1  FIFO has room, from ufifo status bit 0
o_busy  out  1  frame in progress (state != IDLE)
o_grant  out  3  currently granted channel ID; valid while o_busy

Behaviour:
- Clocking and reset: single clock i_clk; i_reset is synchronous, active-high.
- Reset values: state=IDLE, rr pointer=NCH-1, cont[]=0, count=0, csum=0. Outputs o_wr=0, o_ack=0, o_busy=0, o_grant=0, o_data=0.
- Output timing: o_wr, o_data and o_ack are combinational from registered state and the current inputs (zero latency).
  - o_ack[g] == o_wr during DATA.
  - Any write happens only when i_full_n=1.
- IDLE:
  - If any i_req is set, grant the first requester searching upward from rr+1 (mod NCH).
  - Register gnt, clear count and csum, go to HDR.
  - The header is not written in the grant cycle.
- HDR: when i_full_n=1, write o_data={4'hC, cont[gnt], gnt[2:0]}, o_wr=1, then go to DATA. Stall while i_full_n=0.
- DATA:
  - Write condition: i_req[gnt] & i_full_n. When it holds: o_data=i_data[gnt], o_wr=1, o_ack[gnt]=1, count++, csum^=byte.
  - End of frame when the written byte has i_last[gnt]=1 or count reaches MAXBURST:
    - cont[gnt] <= ~i_last[gnt]
    - rr <= gnt
    - next state CSUM if the macro is defined, else IDLE
  - i_last together with count==MAXBURST is treated as last: cont cleared.
  - i_req[gnt] low mid-frame: wait indefinitely; no abandon, no re-arbitration.
  - Requests from other channels are ignored until IDLE.
- Minimum frame overhead: one IDLE cycle between frames. Back-to-back frames from the same sole requester are allowed; the header is then sent with cont=1.
- i_last without i_req is ignored.
- i_reset asserted mid-frame: the partial frame is abandoned; the next frame starts with cont=0.

Optional Feature:
COMMFIFO_TX_ARBITER_CSUM_EN
- Defined: adds a CSUM state after DATA. When i_full_n=1, write o_data=csum (XOR of all data bytes of the frame, header excluded), then go to IDLE.
- Undefined: no CSUM state; DATA returns straight to IDLE and the csum register is not instantiated.

Decomposition:
- Package commfifo_pkg:
  - state enum (IDLE, HDR, DATA, CSUM)
  - HDR_TAG=4'hC
  - header field positions (tag [7:4], cont [3], id [2:0])
  - ID width constant 3
- One natural sub-module: commfifo_rr_pick, a combinational round-robin priority picker (inputs req[NCH] and last grant; outputs grant index and any).

Test Plan:
- Channel 2 alone sends 3 bytes 0x11,0x22,0x33 with last on 0x33, i_full_n=1 -> FIFO sees 0xC2,0x11,0x22,0x33; o_ack[2] pulses 3 times; o_busy drops. With CSUM_EN, a fourth byte 0x00 follows.
- Channels 0,1,3 all request continuously, 1-byte messages with last -> header order 0xC0,0xC1,0xC3,0xC0...; no channel is granted twice while another waits.
- Channel 1 streams 20 bytes with MAXBURST=16 -> frame 0xC1 + 16 bytes, then 0xC9 (cont=1) + 4 bytes. Next message header is 0xC1.
- Hold i_full_n=0 for 5 cycles in HDR and mid-DATA -> o_wr stays 0 and no o_ack while stalled; no byte is lost or duplicated after release.
- Channel 0 drops i_req for 3 cycles mid-frame while channel 2 requests -> arbiter holds grant 0; channel 2 is served only after channel 0's last.
- Assert i_reset during DATA of channel 3 after 2 bytes -> all outputs 0 next cycle; channel 3's next frame header is 0xC3.
